load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits directly upstream of the 256 x 32-bit word-addressed data memory and is its only master.
- Accepts byte-addressed load/store requests from the MEM stage: lb, lbu, lh, lhu, lw, sb, sh, sw.
- Drives the memory's read/write strobes, aligns and sign-/zero-extends load data, and performs read-modify-write for sub-word stores.
- Flags misaligned accesses instead of issuing them.

Parameters:
- ADDR_W, 8: word-address width of the data memory. Byte address is ADDR_W+2 bits.

Ports:
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; handshake when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W+2  byte address
- req_wdata  in  32  store data; byte/half taken from the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- misaligned  out  1  valid with resp_valid; access was not performed
- mem_address  out  ADDR_W  word index = captured addr[ADDR_W+1:2]
- mem_inData  out  32  write data to memory
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_outData  in  32  memory read data, valid the cycle after mem_read

Behaviour:
- Reset (async, rst_n low): state = IDLE; resp_valid = 0, resp_rdata = 0, misaligned = 0, capture registers = 0.
- mem_read and mem_write decode combinationally from state, so both drop immediately on reset.
- Byte order is big-endian:
  - byte offset 0 = bits [31:24] ... offset 3 = bits [7:0]
  - half offset 0 = [31:16], offset 2 = [15:0]
- Misaligned when any of: half with addr[0]=1; word with addr[1:0]!=0; size = 11.
- FSM states: IDLE, LD_RD, LD_WAIT, ST_WR, RMW_RD, RMW_WR.
- IDLE:
  - req_ready = 1; mem strobes 0.
  - On handshake, capture write, size, unsigned, addr and wdata.
  - Misaligned request: stay in IDLE; next cycle resp_valid = 1, misaligned = 1, resp_rdata = 0.
  - Load: go to LD_RD. Word store: go to ST_WR. Byte/half store: go to RMW_RD.
- LD_RD: mem_read = 1 → LD_WAIT.
- LD_WAIT:
  - mem_outData is valid.
  - At the edge: resp_rdata <= selected lane, extended per unsigned; resp_valid <= 1; → IDLE.
- ST_WR:
  - mem_write = 1, mem_inData = wdata.
  - At the edge: memory commits; resp_valid <= 1; → IDLE.
- RMW_RD: mem_read = 1 → RMW_WR.
- RMW_WR:
  - mem_write = 1, mem_read = 0.
  - mem_inData = mem_outData with the target lane replaced by wdata[7:0] or wdata[15:0].
  - At the edge: resp_valid <= 1; → IDLE.
- Latency from handshake cycle (cycle 0) to resp_valid:
  - load: cycle 3
  - word store: cycle 2
  - sub-word store: cycle 3
  - misaligned: cycle 1
- req_ready = 1 only in IDLE. The IDLE cycle that carries resp_valid may accept the next request, giving back-to-back operation.
- resp_valid is high exactly one cycle per accepted request and has no backpressure.
- mem_read && mem_write is never 1 in the same cycle.
- mem_address holds the captured word index in every non-IDLE state and 0 in IDLE.
- req_valid while req_ready = 0 is ignored; the requester holds the request.
- Reset mid-operation: the transaction is dropped and produces no resp_valid. If reset asserts in ST_WR or RMW_WR before the edge, no write occurs.

Test Plan:
1. Preload word 5 = 0x8899AABB; lw addr 0x14 → mem_read high in cycle 1 only; resp_valid in cycle 3 with rdata 0x8899AABB, misaligned = 0.
2. Same word:
   - lb 0x15 → 0xFFFFFF99
   - lbu 0x15 → 0x00000099
   - lh 0x16 → 0xFFFFAABB
   - lhu 0x14 → 0x00008899
3. sb addr 0x17, wdata 0x12345677 → mem_read in cycle 1; mem_write in cycle 2 with mem_inData 0x8899AA77, never overlapping; resp_valid in cycle 3; a following lw 0x14 returns 0x8899AA77.
4. sw 0x14, 0xDEADBEEF issued in the same cycle that resp_valid of a prior load is high → accepted; mem_write in cycle 1; resp_valid in cycle 2; lw 0x14 returns 0xDEADBEEF.
5. lh 0x15, sw 0x16 and size = 11 → each gives resp_valid in cycle 1 with misaligned = 1, rdata 0; no mem_read/mem_write; memory unchanged.
6. sh 0x14 with rst_n pulled low mid-RMW_WR → mem_write drops immediately; word 5 unchanged; no resp_valid; req_ready = 1 after release; outputs at reset values.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
//   req_*        : byte-addressed load/store request from the MEM stage (valid/ready)
//   resp_*       : one-cycle completion pulse, extended load data, misaligned flag
//   mem_*        : strobes, word address and data of the 256 x 32 data memory
// modport slave  : the load/store unit itself
// modport master : the environment (requester plus data memory)
interface load_store_unit_if #(parameter int ADDR_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              misaligned;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_inData;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_outData;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_outData,
    output req_ready, resp_valid, resp_rdata, misaligned,
           mem_address, mem_inData, mem_read, mem_write
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_outData,
    input  req_ready, resp_valid, resp_rdata, misaligned,
           mem_address, mem_inData, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: sole master of the word-addressed data memory.
// Accepts byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw, extracts and extends load
// lanes (big-endian), performs read-modify-write for sub-word stores and
// reports misaligned accesses without touching memory.
// Ports:
//   clk    : clock, all state changes on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : load_store_unit_if.slave (request, response, memory bus)
//
// state   | meaning
// IDLE    | ready for a request; may carry the previous response pulse
// LD_RD   | memory read strobe for a load
// LD_WAIT | read data present, extend and respond
// ST_WR   | full-word write
// RMW_RD  | read of the word a sub-word store will modify
// RMW_WR  | write back the word with the target lane replaced
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  load_store_unit_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LD_RD, LD_WAIT, ST_WR, RMW_RD, RMW_WR} state_t;

  state_t            state, state_nxt;
  logic [1:0]        c_size;
  logic              c_unsigned;
  logic [ADDR_W+1:0] c_addr;
  logic [31:0]       c_wdata;

  logic              hs;
  logic              req_mis;
  logic [1:0]        off;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_ext;
  logic [31:0]       st_merged;

  assign hs  = bus.req_valid && (state == IDLE);
  assign off = c_addr[1:0];

  always_comb begin
    req_mis = 1'b0;
    case (bus.req_size)
      2'b01:   req_mis = bus.req_addr[0];
      2'b10:   req_mis = (bus.req_addr[1:0] != 2'b00);
      2'b11:   req_mis = 1'b1;
      default: req_mis = 1'b0;
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    ld_byte = 8'h00;
    case (off)
      2'd0:    ld_byte = bus.mem_outData[31:24];
      2'd1:    ld_byte = bus.mem_outData[23:16];
      2'd2:    ld_byte = bus.mem_outData[15:8];
      default: ld_byte = bus.mem_outData[7:0];
    endcase
    ld_half = off[1] ? bus.mem_outData[15:0] : bus.mem_outData[31:16];
    case (c_size)
      2'b00:   ld_ext = c_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = c_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = bus.mem_outData;
    endcase
  end

  always_comb begin
    st_merged = bus.mem_outData;
    if (c_size == 2'b00) begin
      case (off)
        2'd0:    st_merged[31:24] = c_wdata[7:0];
        2'd1:    st_merged[23:16] = c_wdata[7:0];
        2'd2:    st_merged[15:8]  = c_wdata[7:0];
        default: st_merged[7:0]   = c_wdata[7:0];
      endcase
    end else if (off[1]) begin
      st_merged[15:0] = c_wdata[15:0];
    end else begin
      st_merged[31:16] = c_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs && !req_mis) begin
          if (!bus.req_write)            state_nxt = LD_RD;
          else if (bus.req_size == 2'b10) state_nxt = ST_WR;
          else                           state_nxt = RMW_RD;
        end
      end
      LD_RD:   state_nxt = LD_WAIT;
      RMW_RD:  state_nxt = RMW_WR;
      LD_WAIT, ST_WR, RMW_WR: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes come straight from the state so a reset kills them immediately.
  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.mem_read    = (state == LD_RD) || (state == RMW_RD);
    bus.mem_write   = (state == ST_WR) || (state == RMW_WR);
    bus.mem_address = (state == IDLE) ? '0 : c_addr[ADDR_W+1:2];
    bus.mem_inData  = 32'h0;
    if (state == ST_WR)  bus.mem_inData = c_wdata;
    if (state == RMW_WR) bus.mem_inData = st_merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_size         <= 2'b00;
      c_unsigned     <= 1'b0;
      c_addr         <= '0;
      c_wdata        <= 32'h0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'h0;
      bus.misaligned <= 1'b0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            c_size     <= bus.req_size;
            c_unsigned <= bus.req_unsigned;
            c_addr     <= bus.req_addr;
            c_wdata    <= bus.req_wdata;
            if (req_mis) begin
              bus.resp_valid <= 1'b1;
              bus.misaligned <= 1'b1;
              bus.resp_rdata <= 32'h0;
            end
          end
        end
        LD_WAIT: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= ld_ext;
        end
        ST_WR, RMW_WR: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= 32'h0;
        end
        default: ;
      endcase
    end
  end

endmodule
